// File: rtl/top_pkg.sv
// top_pkg: shared CSI-2 receive path lane width and RAW10 pixel types
package top_pkg;
    localparam int NUM_LANE = 2;
    typedef logic [8*NUM_LANE-1:0] lane_data_t;
    localparam int RAW10_GROUP_BYTES = 5;
    typedef logic [9:0] pix10_t;
    typedef pix10_t [3:0] raw10_group_t;
endpackage

// File: rtl/csi_rx_raw10_group_decode.sv
// csi_rx_raw10_group_decode: maps one 5-byte RAW10 group onto four 10-bit pixels
module csi_rx_raw10_group_decode
    import top_pkg::*;
(
    input  logic [8*RAW10_GROUP_BYTES-1:0] bytes_i,
    output raw10_group_t                   group_o
);
    // Pixel k takes byte k as its MSBs and bits [2k+1:2k] of byte 4 as its LSBs
    for (genvar i = 0; i < 4; i++) begin : g_pix
        assign group_o[i] = {bytes_i[8*i +: 8], bytes_i[32+2*i +: 2]};
    end
endmodule

// File: rtl/csi_rx_raw10_unpacker.sv
// csi_rx_raw10_unpacker: regroups payload bytes into RAW10 4-pixel groups with line accounting
module csi_rx_raw10_unpacker
    import top_pkg::*;
#(
    parameter int LANES = NUM_LANE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [8*LANES-1:0]   payload,
    input  logic                 payload_valid,
    output logic [39:0]          pixel_data,
    output logic                 pixel_valid,
    output logic                 line_end,
    output logic [15:0]          line_pixels,
    output logic [2:0]           residue
);
    logic [63:0]  buf_q;
    logic [3:0]   cnt_q;
    logic         active_q;
    logic [15:0]  pix_cnt_q;
    logic [63:0]  merged_d;
    logic [3:0]   cnt_d;
    logic         emit;
    raw10_group_t group;

    // Append the incoming bytes just above the buffered ones; bytes above cnt_q are kept zero
    always_comb begin
        merged_d = buf_q | (64'(payload) << {cnt_q, 3'b000});
        cnt_d    = cnt_q + 4'(LANES);
        emit     = cnt_d >= 4'(RAW10_GROUP_BYTES);
    end

    csi_rx_raw10_group_decode u_decode (
        .bytes_i (merged_d[39:0]),
        .group_o (group)
    );

    // Accept/emit while payload flows, flush and report once it stops
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            active_q    <= 1'b0;
            pix_cnt_q   <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            line_end    <= 1'b0;
            line_pixels <= '0;
            residue     <= '0;
        end else begin
            pixel_valid <= 1'b0;
            line_end    <= 1'b0;
            if (enable && payload_valid) begin
                active_q <= 1'b1;
                if (emit) begin
                    pixel_data  <= group;
                    pixel_valid <= 1'b1;
                    buf_q       <= merged_d >> 40;
                    cnt_q       <= cnt_d - 4'(RAW10_GROUP_BYTES);
                    pix_cnt_q   <= (pix_cnt_q >= 16'hFFFC) ? 16'hFFFF : pix_cnt_q + 16'd4;
                end else begin
                    buf_q <= merged_d;
                    cnt_q <= cnt_d;
                end
            end else if (enable && active_q) begin
                line_end    <= 1'b1;
                residue     <= cnt_q[2:0];
                line_pixels <= pix_cnt_q;
                buf_q       <= '0;
                cnt_q       <= '0;
                pix_cnt_q   <= '0;
                active_q    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_csi_rx_raw10_unpacker.sv
// tb_csi_rx_raw10_unpacker: directed checks of the 2-lane and 4-lane RAW10 unpacker
module tb_csi_rx_raw10_unpacker;
    logic        clock = 1'b0;
    logic        reset;
    logic        en2, v2, en4, v4;
    logic [15:0] p2;
    logic [31:0] p4;
    logic [39:0] pd2, pd4;
    logic        pv2, pv4, le2, le4;
    logic [15:0] lp2, lp4;
    logic [2:0]  rs2, rs4;
    int          checks = 0;
    int          passed = 0;
    int          npv;

    always #5 clock = ~clock;

    csi_rx_raw10_unpacker #(.LANES(2)) u2 (
        .clock(clock), .reset(reset), .enable(en2), .payload(p2), .payload_valid(v2),
        .pixel_data(pd2), .pixel_valid(pv2), .line_end(le2), .line_pixels(lp2), .residue(rs2)
    );

    csi_rx_raw10_unpacker #(.LANES(4)) u4 (
        .clock(clock), .reset(reset), .enable(en4), .payload(p4), .payload_valid(v4),
        .pixel_data(pd4), .pixel_valid(pv4), .line_end(le4), .line_pixels(lp4), .residue(rs4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [39:0] grp(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c, input logic [9:0] d);
        return {d, c, b, a};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic w2(input logic [15:0] d, input logic v);
        p2 = d;
        v2 = v;
        tick();
    endtask

    task automatic w4(input logic [31:0] d, input logic v);
        p4 = d;
        v4 = v;
        tick();
    endtask

    initial begin
        reset = 1'b1; en2 = 1'b1; en4 = 1'b1; v2 = 1'b0; v4 = 1'b0; p2 = '0; p4 = '0;
        tick();
        check("reset_pd", pd2, 0);
        check("reset_pv", pv2, 0);
        check("reset_le", le2, 0);
        check("reset_lp", lp2, 0);
        check("reset_rs", rs2, 0);
        reset = 1'b0;
        tick();

        // 2-lane single group
        w2(16'h2211, 1); check("t1_pv_w1", pv2, 0);
        w2(16'h4433, 1); check("t1_pv_w2", pv2, 0);
        w2(16'hAAE4, 1); check("t1_pv_w3", pv2, 1);
        check("t1_group", pd2, grp(10'h044, 10'h089, 10'h0CE, 10'h113));
        w2(16'h0000, 0); check("t1_le", le2, 1);
        check("t1_pv_off", pv2, 0);
        check("t1_lp", lp2, 4);
        check("t1_rs", rs2, 1);
        w2(16'h0000, 0); check("t1_le_pulse", le2, 0);
        check("t1_lp_hold", lp2, 4);
        w2(16'h0000, 0); check("t1_idle_le", le2, 0);

        // 2-lane, 10 bytes in 5 words
        npv = 0;
        w2(16'h0201, 1); npv += int'(pv2);
        w2(16'h0403, 1); npv += int'(pv2);
        w2(16'h0605, 1); check("t2_pv_w3", pv2, 1); npv += int'(pv2);
        check("t2_g1", pd2, grp(10'h005, 10'h009, 10'h00C, 10'h010));
        w2(16'h0807, 1); npv += int'(pv2);
        w2(16'h0A09, 1); check("t2_pv_w5", pv2, 1); npv += int'(pv2);
        check("t2_g2", pd2, grp(10'h01A, 10'h01E, 10'h020, 10'h024));
        w2(16'h0000, 0); check("t2_le", le2, 1);
        check("t2_npv", npv, 2);
        check("t2_lp", lp2, 8);
        check("t2_rs", rs2, 0);
        w2(16'h0000, 0);

        // 4-lane, 20 bytes in 5 words
        w4(32'h44332211, 1); check("t3_pv_w1", pv4, 0);
        w4(32'h030201E4, 1); check("t3_pv_w2", pv4, 1);
        check("t3_g1", pd4, grp(10'h044, 10'h089, 10'h0CE, 10'h113));
        w4(32'h07060504, 1); check("t3_pv_w3", pv4, 1);
        check("t3_g2", pd4, grp(10'h005, 10'h009, 10'h00C, 10'h010));
        w4(32'h0B0A0908, 1); check("t3_pv_w4", pv4, 1);
        check("t3_g3", pd4, grp(10'h01A, 10'h01E, 10'h020, 10'h024));
        w4(32'h0F0E0D0C, 1); check("t3_pv_w5", pv4, 1);
        check("t3_g4", pd4, grp(10'h02F, 10'h033, 10'h034, 10'h038));
        w4(32'h0, 0); check("t3_le", le4, 1);
        check("t3_lp", lp4, 16);
        check("t3_rs", rs4, 0);
        w4(32'h0, 0);

        // back-to-back lines with a one-cycle gap
        w2(16'h2211, 1); w2(16'h4433, 1); w2(16'hAAE4, 1);
        w2(16'h0000, 0); check("t4_le_a", le2, 1);
        check("t4_lp_a", lp2, 4);
        w2(16'h0201, 1); w2(16'h0403, 1);
        w2(16'h0605, 1); check("t4_pv_b", pv2, 1);
        check("t4_g_b", pd2, grp(10'h005, 10'h009, 10'h00C, 10'h010));
        w2(16'h0807, 1); w2(16'h0A09, 1);
        w2(16'h0000, 0); check("t4_le_b", le2, 1);
        check("t4_lp_b", lp2, 8);
        check("t4_rs_b", rs2, 0);
        w2(16'h0000, 0);

        // enable low for 3 cycles mid-line
        w2(16'h0201, 1); w2(16'h0403, 1); w2(16'h0605, 1);
        check("t5_pv_pre", pv2, 1);
        en2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w2(16'hDEAD, 1);
            check("t5_stall_pv", pv2, 0);
            check("t5_stall_le", le2, 0);
            check("t5_stall_pd", pd2, grp(10'h005, 10'h009, 10'h00C, 10'h010));
        end
        en2 = 1'b1;
        w2(16'h0807, 1); check("t5_pv_w4", pv2, 0);
        w2(16'h0A09, 1); check("t5_pv_w5", pv2, 1);
        check("t5_g2", pd2, grp(10'h01A, 10'h01E, 10'h020, 10'h024));
        w2(16'h0000, 0); check("t5_le", le2, 1);
        check("t5_lp", lp2, 8);
        check("t5_rs", rs2, 0);
        w2(16'h0000, 0);

        // reset mid-line with 3 bytes buffered
        w2(16'h0201, 1); w2(16'h0403, 1); w2(16'h0605, 1); w2(16'h0807, 1);
        reset = 1'b1;
        w2(16'h0000, 0);
        check("t6_pd", pd2, 0);
        check("t6_pv", pv2, 0);
        check("t6_lp", lp2, 0);
        check("t6_rs", rs2, 0);
        reset = 1'b0;
        w2(16'h0000, 0); check("t6_no_le", le2, 0);
        w2(16'h2211, 1); w2(16'h4433, 1);
        w2(16'hAAE4, 1); check("t6_pv", pv2, 1);
        check("t6_group", pd2, grp(10'h044, 10'h089, 10'h0CE, 10'h113));
        w2(16'h0000, 0); check("t6_le", le2, 1);
        check("t6_lp_after", lp2, 4);
        check("t6_rs_after", rs2, 1);
        w2(16'h0000, 0);

        // long 4-lane line: 16400 groups saturate the pixel counter
        for (int i = 0; i < 20500; i++) w4(32'h0, 1);
        w4(32'h0, 0); check("t7_le", le4, 1);
        check("t7_lp_sat", lp4, 16'hFFFF);
        check("t7_rs", rs4, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
